pkt_ingress_framer: RTL and testbench
=====================================

// Module: pkt_ingress_framer
// PURPOSE
//  Ingress stage feeding the packet processor enqueue interface (enq_req/sop/eop/pck_len).
//  Accepts a raw valid/ready word stream; word 0 of each packet is a header carrying the length.
//  Validates length vs. actual s_last position, generates sop/eop/len strobes, drops/repairs bad packets.
//  Keeps saturating statistics counters.
// PARAMETERS
//  DATA_WIDTH  32    data word width
//  PCK_LEN     12    length field width; header bits [PCK_LEN-1:0] = packet length in words incl. header
//  MIN_LEN     1     smallest legal length (words)
//  MAX_LEN     1024  largest legal length (words); must be < 2**PCK_LEN
//  CNT_WIDTH   16    statistics counter width
// PORTS
//  clk              in   1           clock
//  rstn             in   1           async active-low reset
//  sw_rst           in   1           sync soft reset, same effect as rstn
//  s_valid          in   1           source word valid
//  s_data           in   DATA_WIDTH  source word
//  s_last           in   1           source last word of packet
//  s_ready          out  1           framer accepts word (combinational)
//  pp_full          in   1           downstream full; blocks start of new packet only
//  enq_req          out  1           write strobe to packet processor
//  enq_in_sop       out  1           first word of forwarded packet
//  enq_wr_data_i    out  DATA_WIDTH  forwarded word
//  enq_in_eop       out  1           last word of forwarded packet
//  enq_pck_len_valid out 1           length qualifier, coincident with enq_in_sop
//  enq_pck_len_i    out  PCK_LEN     length of forwarded packet (header field)
//  pkt_cnt          out  CNT_WIDTH   packets forwarded with exact length
//  drop_cnt         out  CNT_WIDTH   packets dropped for illegal length
//  trunc_cnt        out  CNT_WIDTH   packets ended early by s_last
//  ovr_cnt          out  CNT_WIDTH   packets longer than header length
// BEHAVIOUR
//  Reset (rstn low or sw_rst): state IDLE, all outputs and counters 0; s_ready 0 while rstn low.
//  Accept = s_valid & s_ready. All enq_* outputs registered: accepted word at edge N appears N+1, held 1 cycle.
//  s_ready: IDLE -> !pp_full; FWD, DISCARD -> 1. pp_full ignored mid-packet.
//  wcnt (PCK_LEN bits): words accepted in current packet; len latched from header.
//  IDLE, header accepted:
//   - len<MIN_LEN or len>MAX_LEN: no enq output, drop_cnt++; s_last ? IDLE : DISCARD.
//   - else forward header with sop=1, pck_len_valid=1, pck_len=len, wcnt=1;
//     len==1 & s_last: eop=1, pkt_cnt++, IDLE.
//     len==1 & !s_last: eop=1, ovr_cnt++, DISCARD.
//     len>1 & s_last: eop=1, trunc_cnt++, IDLE.
//     else FWD.
//  FWD, word accepted (wcnt+1 = k):
//   - k==len & s_last: eop, pkt_cnt++, IDLE.
//   - k<len & s_last: eop, trunc_cnt++, IDLE.
//   - k==len & !s_last: eop, ovr_cnt++, DISCARD.
//   - else forward, wcnt=k.
//  DISCARD: consume words, no enq output; s_last -> IDLE.
//  Every forwarded packet has exactly one sop and one eop.
//  pck_len_i reports the header value even when truncated/overrun.
//  Counters saturate at all-ones, never wrap. Only one counter increments per packet.
//  s_valid low mid-packet: gap, no output, state held.
//  Reset mid-packet: downstream sees no eop; framer restarts in IDLE.
// TESTING
//  len=4 hdr + 3 words, s_last on 4th -> enq_req 4 cycles; sop+len=4 on 1st, eop on 4th; pkt_cnt=1.
//  len=1 hdr with s_last -> single cycle sop=eop=1, pck_len=1; pkt_cnt=1.
//  len=6, s_last on word 3 -> 3 words, eop on 3rd; trunc_cnt=1; next packet sop ok.
//  len=2, source sends 5 words -> 2 forwarded, eop on 2nd; words 3-5 absorbed (s_ready=1); ovr_cnt=1.
//  len=0 and len=MAX_LEN+1 headers, each 3 words -> no enq_req; drop_cnt=2.
//  pp_full=1 in IDLE -> s_ready=0, nothing accepted.
//  pp_full rising mid-packet -> packet completes unchanged.
//  rstn pulse mid-packet -> outputs 0.
//  Counters forced near max -> saturate at 2**CNT_WIDTH-1.

Source files
------------

// File: rtl/pkt_ingress_framer.sv
// pkt_ingress_framer: frames a valid/ready word stream into enq sop/eop/len strobes, repairing or dropping bad packets.
module pkt_ingress_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int PCK_LEN    = 12,
  parameter int MIN_LEN    = 1,
  parameter int MAX_LEN    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sw_rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  pp_full,
  output logic                  enq_req,
  output logic                  enq_in_sop,
  output logic [DATA_WIDTH-1:0] enq_wr_data_i,
  output logic                  enq_in_eop,
  output logic                  enq_pck_len_valid,
  output logic [PCK_LEN-1:0]    enq_pck_len_i,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  trunc_cnt,
  output logic [CNT_WIDTH-1:0]  ovr_cnt
);
  localparam logic [1:0] IDLE = 2'd0, FWD = 2'd1, DISC = 2'd2;
  localparam logic [PCK_LEN-1:0] MIN_L = PCK_LEN'(MIN_LEN);
  localparam logic [PCK_LEN-1:0] MAX_L = PCK_LEN'(MAX_LEN);
  logic [1:0] state_q, state_d;
  logic [PCK_LEN-1:0] wcnt_q, wcnt_d, len_q, len_d;
  logic enq_req_q, enq_req_d, sop_q, sop_d, eop_q, eop_d, lv_q, lv_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PCK_LEN-1:0] plen_q, plen_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d, ovr_cnt_q, ovr_cnt_d;
  logic idle, acc, legal, fwd, sop, at_len;
  logic [PCK_LEN-1:0] len_in, cur_len, cur_k;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction

  // In IDLE the header itself is word 1 and carries the length being checked
  assign idle    = state_q == IDLE;
  assign s_ready = rstn & !sw_rst & (!idle | !pp_full);
  assign acc     = s_valid & s_ready;
  assign len_in  = s_data[PCK_LEN-1:0];
  assign legal   = len_in >= MIN_L && len_in <= MAX_L;
  assign cur_len = idle ? len_in : len_q;
  assign cur_k   = idle ? PCK_LEN'(1) : wcnt_q + 1'b1;
  assign at_len  = cur_k == cur_len;
  assign fwd     = acc & (state_q == FWD | idle & legal);
  assign sop     = acc & idle & legal;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      len_q       <= '0;
      enq_req_q   <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      lv_q        <= 1'b0;
      data_q      <= '0;
      plen_q      <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      enq_req_q   <= enq_req_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      lv_q        <= lv_d;
      data_q      <= data_d;
      plen_q      <= plen_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  // Any accepted word that ends or drops the packet leaves FWD; only s_last returns to IDLE
  always_comb begin
    state_d = state_q;
    wcnt_d  = fwd ? cur_k : wcnt_q;
    len_d   = sop ? len_in : len_q;
    if (acc) state_d = (fwd & !at_len & !s_last) ? FWD : s_last ? IDLE : DISC;
    if (sw_rst) begin
      state_d = IDLE;
      wcnt_d  = '0;
      len_d   = '0;
    end
  end

  always_comb begin
    enq_req_d   = fwd;
    sop_d       = sop;
    eop_d       = fwd & (s_last | at_len);
    lv_d        = sop;
    plen_d      = sop ? len_in : '0;
    data_d      = fwd ? s_data : '0;
    pkt_cnt_d   = sat_inc(pkt_cnt_q, fwd & s_last & at_len);
    trunc_cnt_d = sat_inc(trunc_cnt_q, fwd & s_last & !at_len);
    ovr_cnt_d   = sat_inc(ovr_cnt_q, fwd & !s_last & at_len);
    drop_cnt_d  = sat_inc(drop_cnt_q, acc & idle & !legal);
    if (sw_rst) begin
      {enq_req_d, sop_d, eop_d, lv_d} = '0;
      plen_d      = '0;
      data_d      = '0;
      pkt_cnt_d   = '0;
      trunc_cnt_d = '0;
      ovr_cnt_d   = '0;
      drop_cnt_d  = '0;
    end
  end

  assign enq_req           = enq_req_q;
  assign enq_in_sop        = sop_q;
  assign enq_in_eop        = eop_q;
  assign enq_pck_len_valid = lv_q;
  assign enq_wr_data_i     = data_q;
  assign enq_pck_len_i     = plen_q;
  assign pkt_cnt           = pkt_cnt_q;
  assign drop_cnt          = drop_cnt_q;
  assign trunc_cnt         = trunc_cnt_q;
  assign ovr_cnt           = ovr_cnt_q;
endmodule

// File: tb/tb_pkt_ingress_framer.sv
// tb_pkt_ingress_framer: scoreboard bench for pkt_ingress_framer with a narrow counter width to reach saturation.
module tb_pkt_ingress_framer;
  localparam int DW = 32, PL = 12, CW = 4, MAXL = 1024;
  logic clk = 0, rstn = 0, sw_rst = 0, s_valid = 0, s_last = 0, pp_full = 0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, enq_req, enq_in_sop, enq_in_eop, enq_pck_len_valid;
  logic [DW-1:0] enq_wr_data_i;
  logic [PL-1:0] enq_pck_len_i;
  logic [CW-1:0] pkt_cnt, drop_cnt, trunc_cnt, ovr_cnt;
  typedef struct packed {logic [DW-1:0] d; logic sop; logic eop; logic [PL-1:0] len;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int passed = 0, total = 0;
  int e_pkt = 0, e_drop = 0, e_trunc = 0, e_ovr = 0;

  pkt_ingress_framer #(.DATA_WIDTH(DW), .PCK_LEN(PL), .MIN_LEN(1), .MAX_LEN(MAXL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .pp_full(pp_full), .enq_req(enq_req), .enq_in_sop(enq_in_sop),
    .enq_wr_data_i(enq_wr_data_i), .enq_in_eop(enq_in_eop), .enq_pck_len_valid(enq_pck_len_valid),
    .enq_pck_len_i(enq_pck_len_i), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt),
    .ovr_cnt(ovr_cnt));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  always @(negedge clk) if (enq_req) begin
    total++;
    if (exp_q.size() == 0) $display("FAIL unexpected_enq got data=%h sop=%b eop=%b", enq_wr_data_i, enq_in_sop, enq_in_eop);
    else begin
      e = exp_q.pop_front();
      if ({enq_wr_data_i, enq_in_sop, enq_in_eop, enq_pck_len_valid, (enq_in_sop ? enq_pck_len_i : {PL{1'b0}})} !==
          {e.d, e.sop, e.eop, e.sop, (e.sop ? e.len : {PL{1'b0}})})
        $display("FAIL enq_word got data=%h sop=%b eop=%b lv=%b len=%0d exp data=%h sop=%b eop=%b len=%0d",
                 enq_wr_data_i, enq_in_sop, enq_in_eop, enq_pck_len_valid, enq_pck_len_i, e.d, e.sop, e.eop, e.len);
      else passed++;
    end
  end

  function automatic int bump(input int v);
    return v < (1 << CW) - 1 ? v + 1 : v;
  endfunction

  task automatic drive_word(input logic [DW-1:0] w, input logic last);
    int t = 0;
    s_valid = 1; s_data = w; s_last = last;
    #1;
    while (!s_ready && t < 20) begin @(negedge clk); #1; t++; end
    total++;
    if (!s_ready) $display("FAIL ready_timeout got s_ready=%b exp 1", s_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pkt(input int len, input int n, input int gap, input int pfull_at);
    logic legal;
    int f;
    logic [DW-1:0] w;
    legal = len >= 1 && len <= MAXL;
    f = legal ? (n < len ? n : len) : 0;
    for (int i = 0; i < n; i++) begin
      w = $urandom();
      if (i == 0) w[PL-1:0] = len[PL-1:0];
      if (i < f) exp_q.push_back('{w, i == 0, i == f - 1, len[PL-1:0]});
      if (i == pfull_at) pp_full = 1;
      drive_word(w, i == n - 1);
      if (gap > 0) begin s_valid = 0; repeat (gap) @(negedge clk); end
    end
    s_valid = 0; s_last = 0; pp_full = 0;
    if (!legal) e_drop = bump(e_drop);
    else if (n == len) e_pkt = bump(e_pkt);
    else if (n < len) e_trunc = bump(e_trunc);
    else e_ovr = bump(e_ovr);
  endtask

  task automatic check_done(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL %s_drain got %0d pending exp 0", name, exp_q.size());
    else passed++;
    total++;
    if ({pkt_cnt, drop_cnt, trunc_cnt, ovr_cnt} !== {e_pkt[CW-1:0], e_drop[CW-1:0], e_trunc[CW-1:0], e_ovr[CW-1:0]})
      $display("FAIL %s_cnt got pkt=%0d drop=%0d trunc=%0d ovr=%0d exp pkt=%0d drop=%0d trunc=%0d ovr=%0d",
               name, pkt_cnt, drop_cnt, trunc_cnt, ovr_cnt, e_pkt, e_drop, e_trunc, e_ovr);
    else passed++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    e_pkt = 0; e_drop = 0; e_trunc = 0; e_ovr = 0;
  endtask

  task automatic test_reset();
    s_valid = 1; s_data = 32'h4;
    repeat (3) @(negedge clk);
    total++;
    if ({s_ready, enq_req, enq_in_sop, enq_in_eop, enq_pck_len_valid, enq_wr_data_i, enq_pck_len_i} !== '0)
      $display("FAIL reset_outputs got rdy=%b req=%b data=%h exp all 0", s_ready, enq_req, enq_wr_data_i);
    else passed++;
    s_valid = 0;
    rstn = 1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", s_ready);
    else passed++;
    check_done("reset");
  endtask

  task automatic test_exact();
    send_pkt(4, 4, 0, -1);
    check_done("exact");
    send_pkt(1, 1, 0, -1);
    check_done("single");
  endtask

  task automatic test_trunc();
    send_pkt(6, 3, 0, -1);
    send_pkt(3, 3, 0, -1);
    check_done("trunc");
  endtask

  task automatic test_ovr();
    send_pkt(2, 5, 0, -1);
    check_done("ovr");
    send_pkt(1, 3, 0, -1);
    check_done("ovr_len1");
  endtask

  task automatic test_drop();
    send_pkt(0, 3, 0, -1);
    send_pkt(MAXL + 1, 3, 0, -1);
    check_done("drop");
    send_pkt(MAXL, 2, 0, -1);
    check_done("maxlen_trunc");
  endtask

  task automatic test_pp_full();
    pp_full = 1; s_valid = 1; s_data = 32'h2; s_last = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({s_ready, enq_req} !== 2'b00) $display("FAIL pp_full_block got rdy=%b req=%b exp 00", s_ready, enq_req);
      else passed++;
    end
    s_valid = 0; pp_full = 0;
    @(negedge clk);
    send_pkt(2, 2, 0, -1);
    check_done("pp_full");
    send_pkt(4, 4, 0, 1);
    check_done("pp_full_mid");
  endtask

  task automatic test_gap();
    send_pkt(4, 4, 2, -1);
    send_pkt(3, 3, 0, -1);
    check_done("gap");
  endtask

  task automatic test_rst_mid();
    logic [DW-1:0] w;
    w = $urandom(); w[PL-1:0] = 12'd5;
    exp_q.push_back('{w, 1'b1, 1'b0, 12'd5});
    drive_word(w, 0);
    w = $urandom();
    exp_q.push_back('{w, 1'b0, 1'b0, 12'd5});
    drive_word(w, 0);
    #1 rstn = 0;
    #2;
    total++;
    if ({s_ready, enq_req, enq_in_sop, enq_in_eop, enq_pck_len_valid, pkt_cnt, trunc_cnt} !== '0)
      $display("FAIL rst_mid_outputs got rdy=%b req=%b eop=%b exp all 0", s_ready, enq_req, enq_in_eop);
    else passed++;
    s_valid = 0;
    @(negedge clk);
    rstn = 1;
    clear_model();
    @(negedge clk);
    send_pkt(3, 3, 0, -1);
    check_done("rst_mid");
  endtask

  task automatic test_sw_rst();
    logic [DW-1:0] w;
    w = $urandom(); w[PL-1:0] = 12'd4;
    exp_q.push_back('{w, 1'b1, 1'b0, 12'd4});
    drive_word(w, 0);
    s_valid = 0;
    sw_rst = 1;
    @(negedge clk);
    total++;
    if ({enq_req, pkt_cnt, drop_cnt, trunc_cnt, ovr_cnt} !== '0)
      $display("FAIL sw_rst_outputs got req=%b pkt=%0d trunc=%0d exp 0", enq_req, pkt_cnt, trunc_cnt);
    else passed++;
    sw_rst = 0;
    clear_model();
    send_pkt(2, 2, 0, -1);
    check_done("sw_rst");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) send_pkt(1, 1, 0, -1);
    for (int i = 0; i < 17; i++) send_pkt(0, 1, 0, -1);
    check_done("saturate");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_trunc();
    test_ovr();
    test_drop();
    test_pp_full();
    test_gap();
    test_rst_mid();
    test_sw_rst();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
